// File: rtl/mips_pkg.sv
// mips_pkg: register bank constants and the writeback request record shared by the writeback path.
package mips_pkg;
    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int REG_ZERO = 0;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regbank_wb_arbiter_if.sv
// regbank_wb_arbiter_if: writeback requesters, scoreboard and bank write port bundled as one bus.
interface regbank_wb_arbiter_if
    import mips_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
);
    logic              p_valid, p_ready;
    logic [AW-1:0]     p_addr;
    logic [DW-1:0]     p_data;
    logic              m_valid, m_ready;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_data;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic [(1<<AW)-1:0] busy;
    logic              sb_conflict;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic              rw;
    modport slave (
        input  p_valid, p_addr, p_data, m_valid, m_addr, m_data, sb_set, sb_addr,
        output p_ready, m_ready, busy, sb_conflict, wa, wd, rw
    );
    modport master (
        output p_valid, p_addr, p_data, m_valid, m_addr, m_data, sb_set, sb_addr,
        input  p_ready, m_ready, busy, sb_conflict, wa, wd, rw
    );
endinterface

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard: busy mask of registers awaiting an mdu result, plus a pulse on re-issue to a busy register.
module regbank_scoreboard
    import mips_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set,
    input  logic [AW-1:0]       set_addr,
    input  logic                clr,
    input  logic [AW-1:0]       clr_addr,
    output logic [(1<<AW)-1:0]  busy,
    output logic                conflict
);
    logic [(1<<AW)-1:0] busy_q, busy_d;
    logic               conflict_q, conflict_d;
    logic               set_v, clr_v;
    always_comb begin
        set_v = set && set_addr != AW'(REG_ZERO);
        clr_v = clr && clr_addr != AW'(REG_ZERO);
        busy_d = busy_q;
        if (clr_v) busy_d[clr_addr] = 1'b0;
        // set applied last so a same-register set and clear leaves the bit busy
        if (set_v) busy_d[set_addr] = 1'b1;
        conflict_d = set_v && busy_q[set_addr] && !(clr_v && clr_addr == set_addr);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end
    assign busy     = busy_q;
    assign conflict = conflict_q;
endmodule

// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter: arbitrates pipe/mdu writeback onto the registered bank write port and tracks pending mdu results.
// Define WB_STARVE_GUARD_EN to force an mdu grant after STARVE_LIMIT stalled cycles.
module regbank_wb_arbiter
    import mips_pkg::*;
#(
    parameter int DW           = REG_DW,
    parameter int AW           = REG_AW,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    regbank_wb_arbiter_if.slave bus
);
    logic          p_acc, m_acc, starve;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          rw_q, rw_d;
`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        starve = cnt_q == CW'(STARVE_LIMIT);
        cnt_d = (!bus.m_valid || m_acc) ? '0 : starve ? cnt_q : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    assign starve = 1'b0;
`endif
    always_comb begin
        bus.p_ready = rst_n && bus.p_valid && !starve;
        bus.m_ready = rst_n && bus.m_valid && (!bus.p_valid || starve);
        p_acc = bus.p_valid && bus.p_ready;
        m_acc = bus.m_valid && bus.m_ready;
        wa_d = p_acc ? bus.p_addr : m_acc ? bus.m_addr : wa_q;
        wd_d = p_acc ? bus.p_data : m_acc ? bus.m_data : wd_q;
        rw_d = (p_acc || m_acc) && wa_d != AW'(REG_ZERO);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_q <= '0;
            wd_q <= '0;
            rw_q <= 1'b0;
        end else begin
            wa_q <= wa_d;
            wd_q <= wd_d;
            rw_q <= rw_d;
        end
    end
    assign bus.wa = wa_q;
    assign bus.wd = wd_q;
    assign bus.rw = rw_q;
    regbank_scoreboard #(.AW(AW)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (bus.sb_set),
        .set_addr (bus.sb_addr),
        .clr      (m_acc),
        .clr_addr (bus.m_addr),
        .busy     (bus.busy),
        .conflict (bus.sb_conflict)
    );
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb_regbank_wb_arbiter: random and directed writeback traffic checked by a queue scoreboard against a request-level model.
module tb_regbank_wb_arbiter;
    import mips_pkg::*;
    localparam int AW = REG_AW, DW = REG_DW, NR = 1 << AW, LIM = 4;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;
    regbank_wb_arbiter_if #(.AW(AW), .DW(DW)) bus();
    regbank_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    int n_tests = 0, n_fail = 0;
    wb_req_t exp_q[$];
    wb_req_t pend = '0;
    logic [NR-1:0] m_busy = '0;
    logic m_conf = 1'b0, m_rw = 1'b0;
    logic [DW-1:0] m_regs [NR] = '{default: '0};
    logic [DW-1:0] bank [NR] = '{default: '0};
    int m_wait = 0;
    logic pv = 0, mv = 0, sv = 0, acc_p, acc_m;
    logic [AW-1:0] pa = '0, ma = '0, sa = '0;
    logic [DW-1:0] pd = '0, md = '0;

    always @(posedge clk) if (rst_n && bus.rw) bank[bus.wa] <= bus.wd;

    assert property (@(posedge clk) disable iff (!rst_n)
        bus.p_valid && !bus.p_ready |=> bus.p_valid && $stable(bus.p_addr) && $stable(bus.p_data))
        else $error("FAIL handshake_p: pipe request dropped before acceptance");
    assert property (@(posedge clk) disable iff (!rst_n)
        bus.m_valid && !bus.m_ready |=> bus.m_valid && $stable(bus.m_addr) && $stable(bus.m_data))
        else $error("FAIL handshake_m: mdu request dropped before acceptance");

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus: drive at negedge, check readies, advance the reference model.
    task automatic step();
        logic forced, ep, em, conf;
        logic [AW-1:0] a;
        @(negedge clk);
        bus.p_valid = pv; bus.p_addr = pa; bus.p_data = pd;
        bus.m_valid = mv; bus.m_addr = ma; bus.m_data = md;
        bus.sb_set = sv; bus.sb_addr = sa;
        #1;
        if (pend.valid) m_regs[pend.addr] = pend.data;
        pend.valid = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        forced = mv && m_wait >= LIM;
`else
        forced = 1'b0;
`endif
        ep = pv && !forced;
        em = mv && (!pv || forced);
        chk("p_ready", bus.p_ready, ep);
        chk("m_ready", bus.m_ready, em);
        a = ep ? pa : ma;
        m_rw = (ep || em) && a != 0;
        if (m_rw) begin
            pend = '{valid: 1'b1, addr: a, data: ep ? pd : md};
            exp_q.push_back(pend);
        end
        m_wait = (mv && !em) ? m_wait + 1 : 0;
        conf = sv && sa != 0 && m_busy[sa] && !(em && ma == sa);
        if (em && ma != 0) m_busy[ma] = 1'b0;
        if (sv && sa != 0) m_busy[sa] = 1'b1;
        m_conf = conf;
        acc_p = ep;
        acc_m = em;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.p_valid = 1'b1; bus.m_valid = 1'b1; bus.sb_set = 1'b0;
        #1;
        chk("rst_rw", bus.rw, 0);
        chk("rst_wa", bus.wa, 0);
        chk("rst_wd", bus.wd, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_conflict", bus.sb_conflict, 0);
        chk("rst_p_ready", bus.p_ready, 0);
        chk("rst_m_ready", bus.m_ready, 0);
        m_busy = '0; m_conf = 1'b0; m_rw = 1'b0; m_wait = 0; pend = '0;
        exp_q.delete();
        pv = 0; mv = 0; sv = 0;
        repeat (2) @(negedge clk);
        bus.p_valid = 1'b0; bus.m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always begin : monitor
        wb_req_t w;
        @(posedge clk);
        #2;
        if (rst_n) begin
            chk("busy", bus.busy, m_busy);
            chk("sb_conflict", bus.sb_conflict, m_conf);
            chk("rw", bus.rw, m_rw);
            if (bus.rw) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL write_unexpected: got wa=%0h wd=%0h expected no write", bus.wa, bus.wd);
                end else begin
                    w = exp_q.pop_front();
                    chk("wa", bus.wa, w.addr);
                    chk("wd", bus.wd, w.data);
                end
            end
        end
    end

    initial begin
        #1 do_reset();
        repeat (3) step();
        pv = 1; pa = 5; pd = 32'hDEADBEEF;
        step(); pv = 0;
        repeat (2) step();
        chk("bank_r5", bank[5], 32'hDEADBEEF);
        // contention followed by sustained pipe pressure against one mdu request
        mv = 1; ma = 12; md = 32'h5A5A0001;
        for (int c = 0; c < 7; c++) begin
            if (!pv) begin pv = 1; pa = AW'(16 + c); pd = $urandom; end
            step();
            if (acc_p) pv = 0;
            if (acc_m) mv = 0;
        end
        pv = 0;
        step();
        if (acc_m) mv = 0;
        mv = 0;
        step();
        sv = 1; sa = 9; step();
        step();
        sv = 0; step();
        mv = 1; ma = 9; md = 32'h99; sv = 1; sa = 9; step(); mv = 0; sv = 0;
        step();
        mv = 1; ma = 9; md = 32'h98; step(); mv = 0;
        step();
        pv = 1; pa = 0; pd = 32'h1234; step(); pv = 0;
        sv = 1; sa = 0; step(); sv = 0;
        repeat (2) step();
        sv = 1; sa = 7; pv = 1; pa = 3; pd = 32'hCAFE0003;
        step(); pv = 0; sv = 0;
        @(posedge clk); #3;
        chk("rw_pending", bus.rw, 1);
        do_reset();
        repeat (4) step();
        for (int c = 0; c < 2000; c++) begin
            if (!pv && $urandom_range(0, 2) != 0) begin pv = 1; pa = AW'($urandom_range(0, 15)); pd = $urandom; end
            if (!mv && $urandom_range(0, 3) == 0) begin mv = 1; ma = AW'($urandom_range(0, 12)); md = $urandom; end
            sv = $urandom_range(0, 3) == 0;
            sa = AW'($urandom_range(0, 12));
            step();
            if (acc_p) pv = 0;
            if (acc_m) mv = 0;
        end
        sv = 0;
        while (pv || mv) begin
            step();
            if (acc_p) pv = 0;
            if (acc_m) mv = 0;
        end
        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        for (int r = 0; r < NR; r++) chk($sformatf("bank_r%0d", r), bank[r], m_regs[r]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
